picorv32_mem_model: RTL and testbench
=====================================

Name: picorv32_mem_model

Overview:
- Parametrised memory/MMIO responder for the picorv32 native memory interface, used as the standard bench memory for core and co-processor (PCPI/FPU) tests.
- Generalises the fixed single-wait-state model with:
  - configurable depth and access latency;
  - optional pseudo-random stall injection;
  - console and exit MMIO registers;
  - out-of-range error reporting;
  - a side-band preload port;
  - transaction counters.

Parameters:
- MEM_WORDS, 256, memory depth in 32-bit words; byte range 0 .. 4*MEM_WORDS-1.
- LATENCY, 1, minimum cycles from accepted mem_valid to mem_ready; legal 1..15.
- STALL_RANDOM, 0, 1 adds 0..3 extra wait cycles per transfer, taken from an LFSR.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero.
- MMIO_BASE, 32'h1000_0000, console register at MMIO_BASE, exit register at MMIO_BASE+4.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned for unmapped addresses.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- mem_valid  in  1  core request.
- mem_instr  in  1  request is an instruction fetch.
- mem_ready  out  1  one-cycle response pulse.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- ld_en  in  1  preload write enable.
- ld_addr  in  32  preload word index.
- ld_data  in  32  preload data.
- con_valid  out  1  one-cycle pulse on console write.
- con_data  out  8  console byte (mem_wdata[7:0]).
- exit_valid  out  1  sticky; set by a write to the exit register.
- exit_code  out  32  data of the first exit write.
- err_valid  out  1  one-cycle pulse on an unmapped access.
- err_addr  out  32  address of the most recent unmapped access.
- cnt_ifetch, cnt_read, cnt_write  out  32 each  completed-transfer counters.

Behaviour:
- Reset (reset=1 at an edge):
  - FSM goes to IDLE; mem_ready=0, mem_rdata=0.
  - con_valid=0, con_data=0, exit_valid=0, exit_code=0, err_valid=0, err_addr=0.
  - All counters = 0; LFSR = LFSR_SEED.
  - Memory array is NOT cleared.
- Reset mid-transfer: the pending access is dropped with no memory write and no ready pulse. The core re-requests after reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if mem_valid=1 at an edge, latch addr, wdata, wstrb and instr. Load wait_cnt = LATENCY-1 + (STALL_RANDOM ? lfsr[1:0] : 0). Step the LFSR. Go to RESP if wait_cnt==0, else WAIT.
  - WAIT: decrement wait_cnt each cycle; go to RESP when it reaches 0.
  - RESP: mem_ready=1 for exactly one cycle, then return to IDLE. The request is never re-accepted in the same cycle ready is high.
- Resulting ready timing: mem_ready is high in cycle t+LATENCY+stall, where t is the cycle mem_valid was sampled. LATENCY=1 without stall gives ready in the cycle after valid.
- Commit timing: the access is performed at the edge entering RESP, so mem_rdata and side effects are visible together with mem_ready.
- Address decode, word index = addr[31:2]:
  - In range (index < MEM_WORDS):
    - read returns the word;
    - write updates only the strobed bytes.
  - addr==MMIO_BASE:
    - write pulses con_valid and sets con_data=wdata[7:0];
    - read returns 0.
  - addr==MMIO_BASE+4:
    - write sets exit_valid=1; exit_code is captured only when exit_valid was 0;
    - read returns 0.
  - Otherwise (unmapped):
    - read returns ERR_RDATA; write is discarded;
    - err_valid pulses and err_addr is updated;
    - mem_ready is still returned, so the core never hangs.
- Counters: on each RESP cycle exactly one counter increments:
  - cnt_ifetch if instr=1;
  - else cnt_write if wstrb!=0;
  - else cnt_read.
  - Counters saturate at 32'hFFFF_FFFF.
- Preload port:
  - ld_en with ld_addr < MEM_WORDS writes the full word at that edge; out-of-range preloads are ignored.
  - Preload is honoured in any state, including while reset=1.
  - If a preload and a bus write hit the same word on the same edge, the bus write wins.
- Unused inputs are ignored outside IDLE.
- mem_rdata holds its last value when mem_ready=0.

Test Plan:
- LATENCY=1, STALL_RANDOM=0:
  - Preload word 128 = 32'h3F80_0000.
  - Read 0x200 with valid at cycle t -> ready only in cycle t+1, rdata=32'h3F80_0000, cnt_read=1.
- LATENCY=4:
  - Write 0x208 with wstrb=4'b0101, wdata=32'hAABB_CCDD onto word 32'h1122_3344.
  - Read it back -> 32'h11BB_33DD.
  - Each ready arrives exactly 4 cycles after valid; cnt_write=1, cnt_read=1.
- STALL_RANDOM=1, seed 16'hACE1, run 1000 fetches -> ready latency always within LATENCY..LATENCY+3, never two ready cycles back to back, cnt_ifetch=1000.
- MMIO sequence:
  - Write 0x1000_0000 with data 0x41 -> con_valid pulses once, con_data=8'h41.
  - Write 0x1000_0004 with 7, then with 9 -> exit_valid=1, exit_code=7.
  - Read 0x0000_4000 -> rdata=32'hDEAD_BEEF, err_valid pulse, err_addr=32'h0000_4000.
- With LATENCY=3, assert reset during WAIT of a write to 0x204 -> no ready pulse, word 129 unchanged, counters 0.
- On one edge, preload word 130=32'h1 and complete a bus write to 0x208 of 32'h2 -> word 130 reads back 32'h2.

Source files
------------

// File: rtl/picorv32_mem_model.sv
// Bench memory/MMIO responder for the picorv32 native memory interface.
// Latency: mem_ready LATENCY (+0..3 LFSR stall) cycles after mem_valid is sampled.
// Backpressure: one transfer in flight; mem_valid is only sampled in IDLE.
module picorv32_mem_model #(
    parameter int          MEM_WORDS    = 256,
    parameter int          LATENCY      = 1,
    parameter int          STALL_RANDOM = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
    parameter logic [31:0] ERR_RDATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        con_valid,
    output logic [7:0]  con_data,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic [31:0] cnt_ifetch,
    output logic [31:0] cnt_read,
    output logic [31:0] cnt_write
);

    localparam int          AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] DEPTH = 32'(MEM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [4:0]  wait_cnt;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_instr;

    logic [31:0] mem [MEM_WORDS];

    logic          accept;
    logic          commit;
    logic [4:0]    wait_init;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [31:0]   c_word;
    logic [3:0]    c_wstrb;
    logic          c_instr;
    logic          c_in_range;
    logic          c_is_con;
    logic          c_is_exit;
    logic          c_is_write;
    logic [AW-1:0] c_idx;
    logic [AW-1:0] ld_idx;
    logic          ld_hit;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // The access commits on the edge entering RESP; with zero wait that is the
    // accepting edge itself, so the live bus fields are used instead of the latch.
    always_comb begin
        accept    = !reset && (state == S_IDLE) && mem_valid;
        wait_init = 5'(LATENCY - 1) + ((STALL_RANDOM != 0) ? {3'b000, lfsr[1:0]} : 5'd0);
        commit    = (accept && (wait_init == 5'd0)) ||
                    (!reset && (state == S_WAIT) && (wait_cnt == 5'd1));
        if (state == S_IDLE) begin
            c_addr  = mem_addr;
            c_wdata = mem_wdata;
            c_wstrb = mem_wstrb;
            c_instr = mem_instr;
        end else begin
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
            c_instr = req_instr;
        end
        c_word     = {c_addr[31:2], 2'b00};
        c_in_range = ({2'b00, c_addr[31:2]} < DEPTH);
        c_is_con   = !c_in_range && (c_word == MMIO_BASE);
        c_is_exit  = !c_in_range && (c_word == MMIO_BASE + 32'd4);
        c_is_write = (c_wstrb != 4'b0000);
        c_idx      = c_addr[AW+1:2];
        ld_hit     = ld_en && (ld_addr < DEPTH);
        ld_idx     = ld_addr[AW-1:0];
    end

    // Array is never cleared; bus write is issued after the preload so it wins.
    always_ff @(posedge clk) begin
        if (ld_hit) begin
            mem[ld_idx] <= ld_data;
        end
        if (commit && c_in_range && c_is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wstrb[b]) begin
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 5'd0;
            lfsr       <= LFSR_SEED;
            req_addr   <= 32'd0;
            req_wdata  <= 32'd0;
            req_wstrb  <= 4'd0;
            req_instr  <= 1'b0;
            mem_ready  <= 1'b0;
            mem_rdata  <= 32'd0;
            con_valid  <= 1'b0;
            con_data   <= 8'd0;
            exit_valid <= 1'b0;
            exit_code  <= 32'd0;
            err_valid  <= 1'b0;
            err_addr   <= 32'd0;
            cnt_ifetch <= 32'd0;
            cnt_read   <= 32'd0;
            cnt_write  <= 32'd0;
        end else begin
            mem_ready <= 1'b0;
            con_valid <= 1'b0;
            err_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_addr  <= mem_addr;
                        req_wdata <= mem_wdata;
                        req_wstrb <= mem_wstrb;
                        req_instr <= mem_instr;
                        lfsr      <= {lfsr[14:0], lfsr_fb};
                        wait_cnt  <= wait_init;
                        state     <= (wait_init == 5'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 5'd1;
                    if (wait_cnt == 5'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (commit) begin
                mem_ready <= 1'b1;
                if (!c_is_write) begin
                    mem_rdata <= c_in_range ? mem[c_idx] :
                                 (c_is_con || c_is_exit) ? 32'd0 : ERR_RDATA;
                end
                if (c_is_write && c_is_con) begin
                    con_valid <= 1'b1;
                    con_data  <= c_wdata[7:0];
                end
                if (c_is_write && c_is_exit) begin
                    exit_valid <= 1'b1;
                    if (!exit_valid) begin
                        exit_code <= c_wdata;
                    end
                end
                if (!c_in_range && !c_is_con && !c_is_exit) begin
                    err_valid <= 1'b1;
                    err_addr  <= c_addr;
                end
                if (c_instr) begin
                    if (cnt_ifetch != 32'hFFFF_FFFF) cnt_ifetch <= cnt_ifetch + 32'd1;
                end else if (c_is_write) begin
                    if (cnt_write != 32'hFFFF_FFFF) cnt_write <= cnt_write + 32'd1;
                end else begin
                    if (cnt_read != 32'hFFFF_FFFF) cnt_read <= cnt_read + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Directed bench for picorv32_mem_model: four instances (latency 1, 4, 2+random stall, 3)
// driven one at a time; read data is checked against a scoreboard queue.
// Latency is measured in cycles from the sampling edge to the first ready cycle.
module tb_picorv32_mem_model;

    localparam logic [31:0] MMIO = 32'h1000_0000;

    logic             clk = 1'b0;
    logic [3:0]       rst = 4'hF;
    logic [3:0]       mv  = 4'h0;
    logic [3:0]       le  = 4'h0;
    logic             mi  = 1'b0;
    logic [31:0]      ma  = 32'd0;
    logic [31:0]      mw  = 32'd0;
    logic [3:0]       ms  = 4'd0;
    logic [31:0]      la  = 32'd0;
    logic [31:0]      ld  = 32'd0;

    logic [3:0]       rdy, cv, ev, erv;
    logic [3:0][31:0] rd, ec, era, cif, crd, cwr;
    logic [3:0][7:0]  cd;

    int vectors     = 0;
    int miscompares = 0;
    int cv_n        = 0;
    int er_n        = 0;
    int rdy3_n      = 0;

    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    picorv32_mem_model #(.LATENCY(1)) u0 (
        .clk(clk), .reset(rst[0]), .mem_valid(mv[0]), .mem_instr(mi), .mem_ready(rdy[0]),
        .mem_addr(ma), .mem_wdata(mw), .mem_wstrb(ms), .mem_rdata(rd[0]),
        .ld_en(le[0]), .ld_addr(la), .ld_data(ld), .con_valid(cv[0]), .con_data(cd[0]),
        .exit_valid(ev[0]), .exit_code(ec[0]), .err_valid(erv[0]), .err_addr(era[0]),
        .cnt_ifetch(cif[0]), .cnt_read(crd[0]), .cnt_write(cwr[0]));

    picorv32_mem_model #(.LATENCY(4)) u1 (
        .clk(clk), .reset(rst[1]), .mem_valid(mv[1]), .mem_instr(mi), .mem_ready(rdy[1]),
        .mem_addr(ma), .mem_wdata(mw), .mem_wstrb(ms), .mem_rdata(rd[1]),
        .ld_en(le[1]), .ld_addr(la), .ld_data(ld), .con_valid(cv[1]), .con_data(cd[1]),
        .exit_valid(ev[1]), .exit_code(ec[1]), .err_valid(erv[1]), .err_addr(era[1]),
        .cnt_ifetch(cif[1]), .cnt_read(crd[1]), .cnt_write(cwr[1]));

    picorv32_mem_model #(.LATENCY(2), .STALL_RANDOM(1), .LFSR_SEED(16'hACE1)) u2 (
        .clk(clk), .reset(rst[2]), .mem_valid(mv[2]), .mem_instr(mi), .mem_ready(rdy[2]),
        .mem_addr(ma), .mem_wdata(mw), .mem_wstrb(ms), .mem_rdata(rd[2]),
        .ld_en(le[2]), .ld_addr(la), .ld_data(ld), .con_valid(cv[2]), .con_data(cd[2]),
        .exit_valid(ev[2]), .exit_code(ec[2]), .err_valid(erv[2]), .err_addr(era[2]),
        .cnt_ifetch(cif[2]), .cnt_read(crd[2]), .cnt_write(cwr[2]));

    picorv32_mem_model #(.LATENCY(3)) u3 (
        .clk(clk), .reset(rst[3]), .mem_valid(mv[3]), .mem_instr(mi), .mem_ready(rdy[3]),
        .mem_addr(ma), .mem_wdata(mw), .mem_wstrb(ms), .mem_rdata(rd[3]),
        .ld_en(le[3]), .ld_addr(la), .ld_data(ld), .con_valid(cv[3]), .con_data(cd[3]),
        .exit_valid(ev[3]), .exit_code(ec[3]), .err_valid(erv[3]), .err_addr(era[3]),
        .cnt_ifetch(cif[3]), .cnt_read(crd[3]), .cnt_write(cwr[3]));

    // Pulse monitors for instance 3 (each high sample is one cycle).
    always @(negedge clk) begin
        if (cv[3])  cv_n   = cv_n + 1;
        if (erv[3]) er_n   = er_n + 1;
        if (rdy[3]) rdy3_n = rdy3_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int k, input logic [31:0] idx, input logic [31:0] dat);
        @(negedge clk);
        le[k] = 1'b1;
        la    = idx;
        ld    = dat;
        @(negedge clk);
        le[k] = 1'b0;
    endtask

    // Holds mem_valid through the ready cycle like the core does, then checks
    // that ready was a single-cycle pulse.
    task automatic xfer(input int k, input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rd, input int exp_lat);
        int          lat;
        logic [31:0] e;
        if (wstrb == 4'd0) sb_q.push_back(exp_rd);
        @(negedge clk);
        mv[k] = 1'b1;
        mi    = instr;
        ma    = addr;
        mw    = wdata;
        ms    = wstrb;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdy[k] && lat < 40);
        chk("latency", 32'(lat), 32'(exp_lat));
        if (wstrb == 4'd0) begin
            e = sb_q.pop_front();
            chk("rdata", rd[k], e);
        end
        @(negedge clk);
        mv[k] = 1'b0;
        chk("ready_single_cycle", 32'(rdy[k]), 32'd0);
    endtask

    initial begin
        logic [15:0] lfsr_m;
        logic [3:0]  seen;
        int          el;
        int          base;

        // Preload is honoured while reset is asserted.
        preload(0, 32'd128, 32'h3F80_0000);
        @(negedge clk);
        chk("rst_ready",   32'(rdy[0]), 32'd0);
        chk("rst_rdata",   rd[0],       32'd0);
        chk("rst_con_vld", 32'(cv[0]),  32'd0);
        chk("rst_con_dat", 32'(cd[0]),  32'd0);
        chk("rst_exit_vld",32'(ev[0]),  32'd0);
        chk("rst_exit_cd", ec[0],       32'd0);
        chk("rst_err_vld", 32'(erv[0]), 32'd0);
        chk("rst_err_addr",era[0],      32'd0);
        chk("rst_ifetch",  cif[0],      32'd0);
        chk("rst_read",    crd[0],      32'd0);
        chk("rst_write",   cwr[0],      32'd0);
        rst = 4'h0;

        // Latency 1: ready in the cycle after valid.
        xfer(0, 1'b0, 32'h0000_0200, 32'd0, 4'd0, 32'h3F80_0000, 1);
        chk("u0_cnt_read",   crd[0], 32'd1);
        chk("u0_cnt_write",  cwr[0], 32'd0);
        chk("u0_cnt_ifetch", cif[0], 32'd0);

        // Boundaries: last word, low address bits ignored, first unmapped word,
        // out-of-range preload ignored.
        preload(0, 32'd255, 32'hCAFE_F00D);
        xfer(0, 1'b0, 32'h0000_03FC, 32'd0, 4'd0, 32'hCAFE_F00D, 1);
        xfer(0, 1'b0, 32'h0000_03FF, 32'd0, 4'd0, 32'hCAFE_F00D, 1);
        xfer(0, 1'b0, 32'h0000_0400, 32'd0, 4'd0, 32'hDEAD_BEEF, 1);
        preload(0, 32'd0,   32'h0BAD_0000);
        preload(0, 32'd256, 32'hFFFF_FFFF);
        xfer(0, 1'b0, 32'h0000_0000, 32'd0, 4'd0, 32'h0BAD_0000, 1);

        // Preload and bus write to the same word on one edge: bus write wins.
        @(negedge clk);
        mv[0] = 1'b1; mi = 1'b0; ma = 32'h0000_0208; mw = 32'h2; ms = 4'hF;
        le[0] = 1'b1; la = 32'd130; ld = 32'h1;
        @(negedge clk);
        le[0] = 1'b0;
        chk("same_edge_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        mv[0] = 1'b0;
        xfer(0, 1'b0, 32'h0000_0208, 32'd0, 4'd0, 32'h0000_0002, 1);

        // Latency 4: byte-strobed write then read back.
        preload(1, 32'd130, 32'h1122_3344);
        xfer(1, 1'b0, 32'h0000_0208, 32'hAABB_CCDD, 4'b0101, 32'd0, 4);
        xfer(1, 1'b0, 32'h0000_0208, 32'd0, 4'd0, 32'h11BB_33DD, 4);
        chk("u1_cnt_write",  cwr[1], 32'd1);
        chk("u1_cnt_read",   crd[1], 32'd1);
        chk("u1_cnt_ifetch", cif[1], 32'd0);

        // Random stall: latency predicted by an LFSR model stepped per accepted request.
        for (int i = 0; i < 4; i++) preload(2, 32'(i), 32'hF00D_0000 + 32'(i));
        lfsr_m = 16'hACE1;
        seen   = 4'd0;
        for (int i = 0; i < 1000; i++) begin
            el = 2 + int'(lfsr_m[1:0]);
            seen[lfsr_m[1:0]] = 1'b1;
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            xfer(2, 1'b1, 32'(i % 4) * 32'd4, 32'd0, 4'd0, 32'hF00D_0000 + 32'(i % 4), el);
        end
        chk("u2_cnt_ifetch", cif[2],     32'd1000);
        chk("u2_cnt_read",   crd[2],     32'd0);
        chk("u2_stall_span", 32'(seen),  32'hF);

        // MMIO and unmapped accesses on the latency-3 instance.
        preload(3, 32'd129, 32'h0000_0055);
        xfer(3, 1'b0, MMIO, 32'h0000_0041, 4'b0001, 32'd0, 3);
        chk("con_pulses", 32'(cv_n),  32'd1);
        chk("con_data",   32'(cd[3]), 32'h41);
        xfer(3, 1'b0, MMIO + 32'd4, 32'd7, 4'hF, 32'd0, 3);
        xfer(3, 1'b0, MMIO + 32'd4, 32'd9, 4'hF, 32'd0, 3);
        chk("exit_valid", 32'(ev[3]), 32'd1);
        chk("exit_code",  ec[3],      32'd7);
        xfer(3, 1'b0, 32'h0000_4000, 32'd0, 4'd0, 32'hDEAD_BEEF, 3);
        chk("err_pulses", 32'(er_n), 32'd1);
        chk("err_addr",   era[3],    32'h0000_4000);
        xfer(3, 1'b0, MMIO, 32'd0, 4'd0, 32'd0, 3);
        xfer(3, 1'b0, 32'h0000_8000, 32'h1234_5678, 4'hF, 32'd0, 3);
        chk("err_pulses2", 32'(er_n), 32'd2);
        chk("err_addr2",   era[3],    32'h0000_8000);
        chk("con_pulses2", 32'(cv_n), 32'd1);
        chk("u3_cnt_write", cwr[3], 32'd4);
        chk("u3_cnt_read",  crd[3], 32'd2);

        // Reset during WAIT of a write to word 129: dropped, no ready, counters cleared.
        @(negedge clk);
        mv[3] = 1'b1; mi = 1'b0; ma = 32'h0000_0204; mw = 32'hFFFF_FFFF; ms = 4'hF;
        @(negedge clk);
        base   = rdy3_n;
        rst[3] = 1'b1;
        mv[3]  = 1'b0;
        repeat (2) @(negedge clk);
        rst[3] = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_ready", 32'(rdy3_n - base), 32'd0);
        chk("rst_mid_write",  cwr[3],     32'd0);
        chk("rst_mid_read",   crd[3],     32'd0);
        chk("rst_mid_ifetch", cif[3],     32'd0);
        chk("rst_mid_exit",   32'(ev[3]), 32'd0);
        xfer(3, 1'b0, 32'h0000_0204, 32'd0, 4'd0, 32'h0000_0055, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
